// File: rtl/scumv_asc_pkg.sv
// Shared definitions for the ASC subsystem: status bytes returned to the
// UART handler, the frame assembler state encoding and frame sizing.
package scumv_asc_pkg;

  localparam logic [7:0] ASC_ACK_BYTE     = 8'h61;  // 'a'
  localparam logic [7:0] ASC_TIMEOUT_BYTE = 8'h74;  // 't'

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    ISSUE,
    WAIT_DONE,
    RESP
  } asc_state_e;

  // Number of whole bytes needed to carry one address+payload scan frame.
  function automatic int frame_bytes(input int addr_bits, input int payload_bits);
    return (addr_bits + payload_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/asc_frame_assembler_if.sv
// Handshake bundle around the ASC frame assembler: byte stream in from the
// UART handler, scan frame out to the shifter, status byte back to the handler.
// The master modport is the assembler's view; slave is its environment.
interface asc_frame_assembler_if #(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160
);

  logic                    data_valid;
  logic                    data_ready;
  logic [7:0]              data_in;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [ADDR_BITS-1:0]    frame_addr;
  logic [PAYLOAD_BITS-1:0] frame_payload;
  logic                    scan_done;
  logic                    response_valid;
  logic                    response_ready;
  logic [7:0]              response_data;
  logic                    busy;

  modport master (
    input  data_valid, data_in, frame_ready, scan_done, response_ready,
    output data_ready, frame_valid, frame_addr, frame_payload,
           response_valid, response_data, busy
  );

  modport slave (
    output data_valid, data_in, frame_ready, scan_done, response_ready,
    input  data_ready, frame_valid, frame_addr, frame_payload,
           response_valid, response_data, busy
  );

endinterface

// File: rtl/asc_frame_assembler.sv
// Collects a fixed number of bytes into one scan frame, hands it to the
// shifter, waits for completion and returns a one-byte status. A stalled
// partial frame is dropped after an inter-byte timeout and reported with 't'.
module asc_frame_assembler
  import scumv_asc_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160,
  parameter int TIMEOUT_CLKS = 100_000
) (
  input  logic                  clk,
  input  logic                  reset,
  asc_frame_assembler_if.master bus
);

  localparam int FRAME_BYTES = frame_bytes(ADDR_BITS, PAYLOAD_BITS);
  localparam int FRAME_BITS  = ADDR_BITS + PAYLOAD_BITS;
  localparam int CNT_W       = $clog2(FRAME_BYTES);
  localparam int TMO_W       = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CLKS);

  asc_state_e               state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [7:0]               resp_data_q, resp_data_d;
  logic [FRAME_BITS-1:0]    frame_q;
  logic                     byte_hs;

  // Bytes are only taken while a frame is being collected, so nothing is
  // overwritten while the shifter or the handler still owns the result.
  assign bus.data_ready     = (state_q == IDLE) || (state_q == RECV);
  assign byte_hs            = bus.data_valid && bus.data_ready;
  assign bus.frame_valid    = (state_q == ISSUE);
  assign bus.response_valid = (state_q == RESP);
  assign bus.busy           = (state_q != IDLE);
  assign bus.response_data  = resp_data_q;
  assign bus.frame_addr     = frame_q[ADDR_BITS-1:0];
  assign bus.frame_payload  = frame_q[FRAME_BITS-1:ADDR_BITS];

  // State, byte counter, timeout counter and status byte registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      tmo_q       <= '0;
      resp_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state logic; a byte in the timeout cycle takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (byte_hs) begin
          count_d = CNT_W'(1);
          tmo_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (byte_hs) begin
          tmo_d = '0;
          if (count_q == LAST_BYTE) begin
            count_d = '0;
            state_d = ISSUE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else if (tmo_q == TMO_LIMIT) begin
          count_d     = '0;
          tmo_d       = '0;
          resp_data_d = ASC_TIMEOUT_BYTE;
          state_d     = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ISSUE: begin
        if (bus.frame_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.scan_done) begin
          resp_data_d = ASC_ACK_BYTE;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.response_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame store: byte k lands on bits [8k+7:8k]; bits beyond the frame are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
    end else if (byte_hs) begin
      for (int b = 0; b < FRAME_BITS; b++) begin
        if (count_q == CNT_W'(b / 8)) begin
          frame_q[b] <= bus.data_in[3'(b % 8)];
        end
      end
    end
  end

endmodule

// File: tb/tb_asc_frame_assembler.sv
// Directed bench for the ASC frame assembler: full frames, frame and response
// backpressure, inter-byte timeout and its boundary, stray scan_done pulses
// and reset in the middle of a frame.
module tb_asc_frame_assembler;
  import scumv_asc_pkg::*;

  localparam int ADDR_BITS    = 12;
  localparam int PAYLOAD_BITS = 160;
  localparam int TIMEOUT_CLKS = 50;
  localparam int NBYTES       = frame_bytes(ADDR_BITS, PAYLOAD_BITS);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]          tx [NBYTES];
  logic [NBYTES*8-1:0] exp_frame;
  logic [ADDR_BITS-1:0]    exp_addr;
  logic [PAYLOAD_BITS-1:0] exp_payload;

  always #5 clk = ~clk;

  asc_frame_assembler_if #(.ADDR_BITS(ADDR_BITS), .PAYLOAD_BITS(PAYLOAD_BITS)) bus_if ();

  asc_frame_assembler #(
    .ADDR_BITS   (ADDR_BITS),
    .PAYLOAD_BITS(PAYLOAD_BITS),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  task automatic checkOutput(input string tag, input logic [191:0] got, input logic [191:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fill the byte table and the reference frame for one of a few patterns.
  task automatic set_pattern(input int kind);
    for (int k = 0; k < NBYTES; k++) begin
      case (kind)
        0:       tx[k] = (k == 0) ? 8'h23 : (k == 1) ? 8'h01 : 8'hA5;
        1:       tx[k] = 8'(k * 37 + 11);
        2:       tx[k] = 8'(255 - k * 5);
        default: tx[k] = 8'(k * k + 64);
      endcase
    end
    exp_frame = '0;
    for (int k = 0; k < NBYTES; k++) exp_frame[8*k +: 8] = tx[k];
    exp_addr    = exp_frame[ADDR_BITS-1:0];
    exp_payload = exp_frame[ADDR_BITS+PAYLOAD_BITS-1:ADDR_BITS];
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus_if.data_valid = 1'b1;
    bus_if.data_in    = b;
    while (!bus_if.data_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!bus_if.data_ready) checkOutput("byte_accept_stall", bus_if.data_ready, 1);
    tick();
    bus_if.data_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int first, input int last);
    for (int k = first; k <= last; k++) send_byte(tx[k]);
  endtask

  task automatic check_frame(input string tag);
    checkOutput({tag, "_fvalid"},  bus_if.frame_valid, 1);
    checkOutput({tag, "_addr"},    bus_if.frame_addr, exp_addr);
    checkOutput({tag, "_payload"}, bus_if.frame_payload, exp_payload);
  endtask

  // From ISSUE: accept the frame, pulse scan_done, consume the ack.
  task automatic complete_transaction(input string tag);
    bus_if.frame_ready = 1'b1;
    tick();
    checkOutput({tag, "_fvalid_drop"}, bus_if.frame_valid, 0);
    checkOutput({tag, "_rv_before_done"}, bus_if.response_valid, 0);
    bus_if.scan_done = 1'b1;
    tick();
    bus_if.scan_done = 1'b0;
    checkOutput({tag, "_rvalid"}, bus_if.response_valid, 1);
    checkOutput({tag, "_rdata"},  bus_if.response_data, 8'h61);
    bus_if.response_ready = 1'b1;
    tick();
    bus_if.response_ready = 1'b0;
    checkOutput({tag, "_idle"}, bus_if.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    logic early;
    bus_if.data_valid     = 1'b0;
    bus_if.data_in        = 8'h00;
    bus_if.frame_ready    = 1'b0;
    bus_if.scan_done      = 1'b0;
    bus_if.response_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    checkOutput("rst_dready",  bus_if.data_ready, 1);
    checkOutput("rst_fvalid",  bus_if.frame_valid, 0);
    checkOutput("rst_addr",    bus_if.frame_addr, 0);
    checkOutput("rst_payload", bus_if.frame_payload, 0);
    checkOutput("rst_rvalid",  bus_if.response_valid, 0);
    checkOutput("rst_rdata",   bus_if.response_data, 0);
    checkOutput("rst_busy",    bus_if.busy, 0);

    // Full frame with the shifter ready
    set_pattern(0);
    bus_if.frame_ready = 1'b1;
    applyStimulus(0, NBYTES - 2);
    checkOutput("full_fvalid_early", bus_if.frame_valid, 0);
    checkOutput("full_busy", bus_if.busy, 1);
    applyStimulus(NBYTES - 1, NBYTES - 1);
    checkOutput("full_fvalid", bus_if.frame_valid, 1);
    checkOutput("full_addr_const", bus_if.frame_addr, 12'h123);
    checkOutput("full_payload_const", bus_if.frame_payload, {4'h5, {19{8'hA5}}, 4'h0});
    checkOutput("full_payload_model", bus_if.frame_payload, exp_payload);
    checkOutput("full_dready", bus_if.data_ready, 0);
    complete_transaction("full");

    // Frame backpressure with a stray byte offered
    set_pattern(1);
    bus_if.frame_ready = 1'b0;
    applyStimulus(0, NBYTES - 1);
    check_frame("bp");
    bus_if.data_valid = 1'b1;
    bus_if.data_in    = 8'hEE;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.frame_valid !== 1'b1 || bus_if.frame_addr !== exp_addr ||
          bus_if.frame_payload !== exp_payload || bus_if.data_ready !== 1'b0) bad++;
      tick();
    end
    checkOutput("bp_stable_cycles_bad", bad, 0);
    bus_if.data_valid  = 1'b0;
    bus_if.frame_ready = 1'b1;
    tick();
    checkOutput("bp_fvalid_drop", bus_if.frame_valid, 0);
    bus_if.scan_done = 1'b1;
    tick();
    bus_if.scan_done = 1'b0;

    // Response backpressure
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.response_valid !== 1'b1 || bus_if.response_data !== 8'h61 ||
          bus_if.data_ready !== 1'b0) bad++;
      tick();
    end
    checkOutput("rbp_stable_cycles_bad", bad, 0);
    bus_if.response_ready = 1'b1;
    tick();
    bus_if.response_ready = 1'b0;
    checkOutput("rbp_idle", bus_if.busy, 0);
    checkOutput("rbp_dready", bus_if.data_ready, 1);
    checkOutput("bp_stray_byte_addr", bus_if.frame_addr, exp_addr);
    checkOutput("bp_stray_byte_payload", bus_if.frame_payload, exp_payload);

    // Stray scan_done in IDLE and RECV
    bus_if.scan_done = 1'b1;
    tick();
    bus_if.scan_done = 1'b0;
    tick();
    checkOutput("spur_idle_rvalid", bus_if.response_valid, 0);
    checkOutput("spur_idle_busy", bus_if.busy, 0);
    set_pattern(2);
    applyStimulus(0, 2);
    bus_if.scan_done = 1'b1;
    tick();
    bus_if.scan_done = 1'b0;
    tick();
    checkOutput("spur_recv_rvalid", bus_if.response_valid, 0);
    checkOutput("spur_recv_dready", bus_if.data_ready, 1);

    // Inter-byte timeout after 10 bytes
    applyStimulus(3, 9);
    early = 1'b0;
    for (int i = 0; i <= TIMEOUT_CLKS; i++) begin
      if (bus_if.response_valid || bus_if.frame_valid) early = 1'b1;
      tick();
    end
    checkOutput("tmo_not_early", early, 0);
    checkOutput("tmo_rvalid", bus_if.response_valid, 1);
    checkOutput("tmo_rdata", bus_if.response_data, 8'h74);
    checkOutput("tmo_fvalid", bus_if.frame_valid, 0);
    checkOutput("tmo_dready", bus_if.data_ready, 0);
    bus_if.response_ready = 1'b1;
    tick();
    bus_if.response_ready = 1'b0;
    checkOutput("tmo_idle", bus_if.busy, 0);

    // Fresh frame after timeout starts at byte 0
    set_pattern(1);
    applyStimulus(0, NBYTES - 1);
    check_frame("post_tmo");
    complete_transaction("post_tmo");

    // Byte arriving exactly in the timeout cycle
    set_pattern(2);
    bus_if.frame_ready = 1'b0;
    applyStimulus(0, 4);
    for (int i = 0; i < TIMEOUT_CLKS; i++) tick();
    applyStimulus(5, 5);
    checkOutput("edge_rvalid", bus_if.response_valid, 0);
    checkOutput("edge_busy", bus_if.busy, 1);
    checkOutput("edge_dready", bus_if.data_ready, 1);
    applyStimulus(6, NBYTES - 1);
    check_frame("edge");
    complete_transaction("edge");

    // Reset after 7 bytes
    set_pattern(3);
    bus_if.frame_ready = 1'b0;
    applyStimulus(0, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mrst_busy",    bus_if.busy, 0);
    checkOutput("mrst_dready",  bus_if.data_ready, 1);
    checkOutput("mrst_fvalid",  bus_if.frame_valid, 0);
    checkOutput("mrst_addr",    bus_if.frame_addr, 0);
    checkOutput("mrst_payload", bus_if.frame_payload, 0);
    checkOutput("mrst_rdata",   bus_if.response_data, 0);
    tick();
    tick();
    checkOutput("mrst_no_resp", bus_if.response_valid, 0);
    applyStimulus(0, NBYTES - 1);
    check_frame("mrst");
    complete_transaction("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
